// File: rtl/conv_result_drain.sv
// Drains the 16-lane MAC array: captures accumulators, requantizes to int8, presents a packed word.
// Optional build macro CONV_DRAIN_RELU_EN clamps negative lanes to zero after saturation.
module conv_result_drain #(
    parameter int LANES = 16,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     convDone,
    input  logic [LANES*ACC_W-1:0]   convResult_in,
    input  logic [4:0]               shift_in,
    output logic                     computeClear_out,
    output logic [LANES*OUT_W-1:0]   result_out,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [1:0] {
        IDLE,
        QUANT,
        HOLD
    } state_t;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

    state_t                 state;
    logic [LANES*ACC_W-1:0] acc_q;
    logic [4:0]             shift_q;
    logic [LANES*OUT_W-1:0] packed_word;

    // One extra bit of headroom keeps the rounding add from wrapping at the int32 extremes.
    function automatic logic [OUT_W-1:0] quant_lane(input logic [ACC_W-1:0] acc,
                                                    input logic [4:0]       s);
        logic [ACC_W:0]        one_v;
        logic [ACC_W:0]        rnd;
        logic [ACC_W:0]        sum;
        logic signed [ACC_W:0] q;
        logic [OUT_W-1:0]      r;
        one_v = {{ACC_W{1'b0}}, 1'b1};
        rnd   = (s != 5'd0) ? (one_v << (s - 5'd1)) : '0;
        sum   = {acc[ACC_W-1], acc} + rnd;
        q     = $signed(sum) >>> s;
        if (q > SAT_MAX)
            r = SAT_MAX[OUT_W-1:0];
        else if (q < SAT_MIN)
            r = SAT_MIN[OUT_W-1:0];
        else
            r = q[OUT_W-1:0];
`ifdef CONV_DRAIN_RELU_EN
        if (r[OUT_W-1])
            r = '0;
`endif
        return r;
    endfunction

    always_comb begin
        packed_word = '0;
        for (int i = 0; i < LANES; i++)
            packed_word[i*OUT_W +: OUT_W] = quant_lane(acc_q[i*ACC_W +: ACC_W], shift_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            acc_q            <= '0;
            shift_q          <= '0;
            computeClear_out <= 1'b0;
            result_out       <= '0;
            result_valid     <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    computeClear_out <= 1'b0;
                    if (convDone) begin
                        acc_q            <= convResult_in;
                        shift_q          <= shift_in;
                        computeClear_out <= 1'b1;
                        busy             <= 1'b1;
                        state            <= QUANT;
                    end
                end
                QUANT: begin
                    computeClear_out <= 1'b0;
                    result_out       <= packed_word;
                    result_valid     <= 1'b1;
                    state            <= HOLD;
                    if (convDone)
                        overrun <= 1'b1;
                end
                HOLD: begin
                    computeClear_out <= 1'b0;
                    // A handshake edge frees the capture registers, so a coincident convDone is taken.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (convDone) begin
                            acc_q            <= convResult_in;
                            shift_q          <= shift_in;
                            computeClear_out <= 1'b1;
                            state            <= QUANT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (convDone) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    computeClear_out <= 1'b0;
                    result_valid     <= 1'b0;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain; expectations follow CONV_DRAIN_RELU_EN when defined.
module tb_conv_result_drain;

    localparam int LANES = 16;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;

`ifdef CONV_DRAIN_RELU_EN
    localparam logic [7:0] E_NEG1 = 8'h00;
    localparam logic [7:0] E_MIN  = 8'h00;
    localparam logic [7:0] E_M125 = 8'h00;
`else
    localparam logic [7:0] E_NEG1 = 8'hFF;
    localparam logic [7:0] E_MIN  = 8'h80;
    localparam logic [7:0] E_M125 = 8'h83;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   convDone;
    logic [LANES*ACC_W-1:0] convResult_in;
    logic [4:0]             shift_in;
    logic                   computeClear_out;
    logic [LANES*OUT_W-1:0] result_out;
    logic                   result_valid;
    logic                   result_ready;
    logic                   busy;
    logic                   overrun;

    int checks = 0;
    int errors = 0;
    int clear_count;
    logic [ACC_W-1:0]       lane_val [LANES];
    logic [LANES*OUT_W-1:0] exp_word;

    conv_result_drain #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .convDone         (convDone),
        .convResult_in    (convResult_in),
        .shift_in         (shift_in),
        .computeClear_out (computeClear_out),
        .result_out       (result_out),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .overrun          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clear_count <= 0;
        else if (computeClear_out)
            clear_count <= clear_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadLanes(input logic [4:0] s);
        for (int i = 0; i < LANES; i++)
            convResult_in[i*ACC_W +: ACC_W] = lane_val[i];
        shift_in = s;
    endtask

    task automatic setAllLanes(input logic [ACC_W-1:0] v);
        for (int i = 0; i < LANES; i++)
            lane_val[i] = v;
    endtask

    task automatic applyStimulus(input logic done, input logic ready);
        convDone     = done;
        result_ready = ready;
        tick();
        convDone = 1'b0;
    endtask

    // Capture with ready low and stop in HOLD with the word valid.
    task automatic captureToHold(input logic [4:0] s);
        loadLanes(s);
        applyStimulus(1'b1, 1'b0);
        tick();
    endtask

    function automatic logic [7:0] laneOf(input logic [LANES*OUT_W-1:0] w, input int i);
        return w[i*OUT_W +: OUT_W];
    endfunction

    initial begin
        rst_n         = 1'b0;
        convDone      = 1'b0;
        result_ready  = 1'b0;
        convResult_in = '0;
        shift_in      = '0;
        setAllLanes('0);
        #3;
        checkOutput("reset_result_out", 128'(result_out), 128'd0);
        checkOutput("reset_valid", 128'(result_valid), 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_clear", 128'(computeClear_out), 128'd0);
        checkOutput("reset_overrun", 128'(overrun), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] basic capture");
        setAllLanes(32'd1000);
        loadLanes(5'd3);
        applyStimulus(1'b1, 1'b1);
        checkOutput("basic_clear_hi", 128'(computeClear_out), 128'd1);
        checkOutput("basic_valid_lo", 128'(result_valid), 128'd0);
        checkOutput("basic_busy", 128'(busy), 128'd1);
        tick();
        checkOutput("basic_clear_lo", 128'(computeClear_out), 128'd0);
        checkOutput("basic_valid_hi", 128'(result_valid), 128'd1);
        checkOutput("basic_word", 128'(result_out), {16{8'h7D}});
        tick();
        checkOutput("basic_xfer_valid", 128'(result_valid), 128'd0);
        checkOutput("basic_xfer_busy", 128'(busy), 128'd0);
        checkOutput("basic_word_kept", 128'(result_out), {16{8'h7D}});
        checkOutput("basic_clear_count", 128'(clear_count), 128'd1);

        $display("[TB] rounding and saturation");
        setAllLanes('0);
        lane_val[0] = 32'd12;
        lane_val[1] = 32'hFFFF_FFF4;
        captureToHold(5'd3);
        checkOutput("round_pos_half", 128'(laneOf(result_out, 0)), 128'h02);
        checkOutput("round_neg_half", 128'(laneOf(result_out, 1)), 128'(E_NEG1));
        checkOutput("round_zero_lane", 128'(laneOf(result_out, 7)), 128'h00);
        applyStimulus(1'b0, 1'b1);
        setAllLanes('0);
        lane_val[2] = 32'd100000;
        lane_val[3] = 32'hFFFE_7960;
        captureToHold(5'd4);
        checkOutput("sat_pos", 128'(laneOf(result_out, 2)), 128'h7F);
        checkOutput("sat_neg", 128'(laneOf(result_out, 3)), 128'(E_MIN));
        applyStimulus(1'b0, 1'b1);
        setAllLanes('0);
        lane_val[4] = 32'h8000_0000;
        lane_val[5] = 32'h7FFF_FFFF;
        captureToHold(5'd0);
        checkOutput("shift0_min", 128'(laneOf(result_out, 4)), 128'(E_MIN));
        checkOutput("shift0_max", 128'(laneOf(result_out, 5)), 128'h7F);
        applyStimulus(1'b0, 1'b1);
        captureToHold(5'd31);
        checkOutput("shift31_min", 128'(laneOf(result_out, 4)), 128'(E_NEG1));
        checkOutput("shift31_max", 128'(laneOf(result_out, 5)), 128'h01);
        applyStimulus(1'b0, 1'b1);
        result_ready = 1'b0;

        $display("[TB] backpressure");
        setAllLanes(32'd1000);
        captureToHold(5'd3);
        checkOutput("bp_overrun_pre", 128'(overrun), 128'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                convResult_in = {LANES{32'd5}};
                shift_in      = 5'd0;
                convDone      = 1'b1;
            end
            tick();
            convDone = 1'b0;
            checkOutput("bp_valid_stable", 128'(result_valid), 128'd1);
            checkOutput("bp_word_stable", 128'(result_out), {16{8'h7D}});
        end
        checkOutput("bp_overrun", 128'(overrun), 128'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("bp_xfer_valid", 128'(result_valid), 128'd0);
        checkOutput("bp_xfer_busy", 128'(busy), 128'd0);
        result_ready = 1'b0;
        tick();
        checkOutput("bp_single_xfer", 128'(result_valid), 128'd0);

        $display("[TB] back-to-back");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        setAllLanes(32'd500);
        captureToHold(5'd2);
        checkOutput("b2b_first_word", 128'(result_out), {16{8'h7D}});
        for (int i = 0; i < LANES; i++) begin
            lane_val[i] = (i % 2 == 0) ? 32'hFFFF_FE0C : 32'd500;
            exp_word[i*OUT_W +: OUT_W] = (i % 2 == 0) ? E_M125 : 8'h7D;
        end
        loadLanes(5'd2);
        applyStimulus(1'b1, 1'b1);
        checkOutput("b2b_valid_drop", 128'(result_valid), 128'd0);
        checkOutput("b2b_clear_hi", 128'(computeClear_out), 128'd1);
        checkOutput("b2b_busy", 128'(busy), 128'd1);
        result_ready = 1'b0;
        tick();
        checkOutput("b2b_second_valid", 128'(result_valid), 128'd1);
        checkOutput("b2b_relu_lane0", 128'(laneOf(result_out, 0)), 128'(E_M125));
        checkOutput("b2b_relu_lane1", 128'(laneOf(result_out, 1)), 128'h7D);
        checkOutput("b2b_second_word", 128'(result_out), 128'(exp_word));
        checkOutput("b2b_overrun", 128'(overrun), 128'd0);
        checkOutput("b2b_clear_count", 128'(clear_count), 128'd2);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_overrun_set", 128'(overrun), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_hold_valid", 128'(result_valid), 128'd0);
        checkOutput("rst_hold_busy", 128'(busy), 128'd0);
        checkOutput("rst_hold_clear", 128'(computeClear_out), 128'd0);
        checkOutput("rst_hold_overrun", 128'(overrun), 128'd0);
        rst_n = 1'b1;
        tick();
        loadLanes(5'd2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_quant_clear_pre", 128'(computeClear_out), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_quant_clear", 128'(computeClear_out), 128'd0);
        checkOutput("rst_quant_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("rst_result_lost", 128'(result_valid), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
